// File: rtl/plac_code_pkg.sv
// Shared constants, mode/state encodings and the thermometer helper for the
// stage-code generator.
package plac_code_pkg;

  localparam int CODE_W = 13;
  localparam int T1_W   = 14;
  localparam int T2_W   = 6;
  localparam int T5_W   = 15;

  localparam int T1_MAX = 14;
  localparam int T2_MAX = 6;
  localparam int T5_MAX = 15;

  localparam logic [1:0] MODE_EXT  = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Sets the 'value' LSBs of a word limited to 'width' bits.
  function automatic logic [T5_W-1:0] thermo(input logic [3:0] value, input int width);
    logic [T5_W-1:0] r;
    for (int i = 0; i < T5_MAX; i++) begin
      r[i] = (i < int'(value)) && (i < width);
    end
    return r;
  endfunction

endpackage

// File: rtl/plac_code_split.sv
// Combinational split of a 13-bit code into the five stage values; the overlap
// bits 9, 7, 5 and 3 are claimed greedily by the more significant stage.
module plac_code_split
  import plac_code_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [3:0]        t1v,
  output logic [2:0]        t2v,
  output logic [2:0]        t3v,
  output logic [2:0]        t4v,
  output logic [3:0]        t5v
);

  // Returns {carry_to_next_stage, stage_value} for a 3-bit middle stage.
  function automatic logic [3:0] fold(input logic [2:0] s);
    logic [3:0] r;
    if (s == 3'd7) begin
      r = {1'b1, 3'(T2_MAX)};
    end else begin
      r = {1'b0, s};
    end
    return r;
  endfunction

  logic       m2;
  logic [3:0] r2;
  logic [3:0] r3;
  logic [3:0] r4;

  always_comb begin
    t1v = code[12:9];
    m2  = 1'b0;
    if (code[12:9] == 4'd15) begin
      t1v = 4'(T1_MAX);
      m2  = 1'b1;
    end else begin
      t1v = code[12:9];
      m2  = 1'b0;
    end
    r2  = fold({m2, code[8:7]});
    r3  = fold({r2[3], code[6:5]});
    r4  = fold({r3[3], code[4:3]});
    t2v = r2[2:0];
    t3v = r3[2:0];
    t4v = r4[2:0];
    t5v = {r4[3], code[2:0]};
  end

endmodule

// File: rtl/plac_stage_code_gen.sv
// Burst generator that splits codes into per-stage thermometer words and
// presents them with the same stage-to-stage skew as the sub-ranging ADC.
module plac_stage_code_gen
  import plac_code_pkg::*;
#(
  parameter logic [12:0] RAMP_STEP = 13'd1,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [CODE_W-1:0] ramp_init,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [T1_W-1:0]   t1,
  output logic [T2_W-1:0]   t2,
  output logic [T2_W-1:0]   t3,
  output logic [T2_W-1:0]   t4,
  output logic [T5_W-1:0]   t5,
  output logic [4:0]        stage_valid,
  output logic              busy,
  output logic              done
);

  state_e            state, state_next;
  logic [1:0]        mode_r;
  logic [CNT_W-1:0]  remaining;
  logic [CODE_W-1:0] ramp_code;
  logic [2:0]        drain_cnt;
  logic              ext_mode, accept, finish;
  logic [CODE_W-1:0] acc_code;

  logic [CODE_W-1:0] c0;
  logic              v0;
  logic [3:0]        s1, s5;
  logic [2:0]        s2, s3, s4;
  logic [2:0]        d2, d3a, d3b, d4a, d4b, d4c;
  logic [3:0]        d5a, d5b, d5c, d5d;

  plac_code_split u_split (
    .code (c0),
    .t1v  (s1),
    .t2v  (s2),
    .t3v  (s3),
    .t4v  (s4),
    .t5v  (s5)
  );

  always_comb begin
    case (mode_r)
      MODE_UP, MODE_DOWN:  ext_mode = 1'b0;
      MODE_EXT, MODE_RSVD: ext_mode = 1'b1;
      default:             ext_mode = 1'b1;
    endcase
  end

  assign in_ready = (state == ST_RUN) && ext_mode;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DRAIN holds for at least four cycles so an empty burst still reports done
  // at the same point the fifth stage would have finished.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    acc_code   = ramp_code;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (num_samples == '0) ? ST_DRAIN : ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ext_mode) begin
          accept   = in_valid;
          acc_code = in_code;
        end else begin
          accept   = 1'b1;
          acc_code = ramp_code;
        end
        if (accept && (remaining == CNT_W'(1))) begin
          state_next = ST_DRAIN;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!v0 && (stage_valid[3:0] == 4'd0) && (drain_cnt >= 3'd4)) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r    <= MODE_EXT;
      remaining <= '0;
      ramp_code <= '0;
      drain_cnt <= 3'd0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (state != ST_DRAIN) begin
        drain_cnt <= 3'd0;
      end else if (drain_cnt != 3'd7) begin
        drain_cnt <= drain_cnt + 3'd1;
      end else begin
        drain_cnt <= drain_cnt;
      end
      if ((state == ST_IDLE) && start) begin
        mode_r    <= mode;
        remaining <= num_samples;
        ramp_code <= ramp_init;
      end else if (accept) begin
        remaining <= remaining - CNT_W'(1);
        if (mode_r == MODE_UP) begin
          ramp_code <= ramp_code + RAMP_STEP;
        end else if (mode_r == MODE_DOWN) begin
          ramp_code <= ramp_code - RAMP_STEP;
        end else begin
          ramp_code <= ramp_code;
        end
      end else begin
        remaining <= remaining;
      end
    end
  end

  // Bubbles enter as code 0, which splits to all-zero words downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      c0 <= '0;  v0 <= 1'b0;  stage_valid <= 5'd0;
      t1 <= '0;  t2 <= '0;  t3 <= '0;  t4 <= '0;  t5 <= '0;
      d2 <= '0;  d3a <= '0; d3b <= '0;
      d4a <= '0; d4b <= '0; d4c <= '0;
      d5a <= '0; d5b <= '0; d5c <= '0; d5d <= '0;
    end else begin
      v0          <= accept;
      c0          <= accept ? acc_code : 13'd0;
      stage_valid <= {stage_valid[3:0], v0};
      t1  <= T1_W'(thermo(s1, T1_W));
      d2  <= s2;
      t2  <= T2_W'(thermo({1'b0, d2}, T2_W));
      d3a <= s3;  d3b <= d3a;
      t3  <= T2_W'(thermo({1'b0, d3b}, T2_W));
      d4a <= s4;  d4b <= d4a;  d4c <= d4b;
      t4  <= T2_W'(thermo({1'b0, d4c}, T2_W));
      d5a <= s5;  d5b <= d5a;  d5c <= d5b;  d5d <= d5c;
      t5  <= thermo(d5d, T5_W);
    end
  end

endmodule

// File: tb/tb_plac_stage_code_gen.sv
// Randomized bench: a cycle-level scoreboard derives every output from the
// history of accepted codes using greedy arithmetic on stage weights.
module tb_plac_stage_code_gen;

  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        start;
  logic [15:0] num_samples;
  logic [12:0] ramp_init;
  logic [12:0] in_code;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] t1;
  logic [5:0]  t2, t3, t4;
  logic [14:0] t5;
  logic [4:0]  stage_valid;
  logic        busy;
  logic        done;

  logic [12:0] x_code;
  logic [3:0]  x_t1v, x_t5v;
  logic [2:0]  x_t2v, x_t3v, x_t4v;

  int n_cmp = 0;
  int n_err = 0;

  int edge_n = 0;
  bit m_active = 1'b0, m_run = 1'b0, m_ext = 1'b1, m_up = 1'b0;
  int m_left = 0, m_ramp = 0, d_edge = -1;
  bit exp_done = 1'b0;
  bit h_val [0:5];
  int h_code [0:5];
  int pc [0:4][0:15];
  logic [12:0] code_q[$];
  bit valid_q[$];

  plac_stage_code_gen dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .num_samples(num_samples),
    .ramp_init(ramp_init), .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .stage_valid(stage_valid),
    .busy(busy), .done(done)
  );

  plac_code_split u_xsplit (
    .code(x_code), .t1v(x_t1v), .t2v(x_t2v), .t3v(x_t3v), .t4v(x_t4v), .t5v(x_t5v)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Greedy value of stage k: largest multiple of the stage weight not above
  // what remains, clamped to the stage maximum.
  function automatic int stage_val(input int c, input int k);
    int r, v, w, mx;
    r = c;
    v = 0;
    for (int j = 1; j <= k; j++) begin
      w  = (j == 1) ? 512 : (j == 2) ? 128 : (j == 3) ? 32 : (j == 4) ? 8 : 1;
      mx = (j == 1) ? 14 : (j == 5) ? 15 : 6;
      v  = r / w;
      if (v > mx) v = mx;
      r = r - v * w;
    end
    return v;
  endfunction

  function automatic int therm(input int v);
    return (1 << v) - 1;
  endfunction

  task automatic step();
    bit acc;
    int acc_code, e, asm_code;
    int ev [1:5];
    logic [4:0] exp_sv;
    @(posedge clk);
    edge_n++;
    acc = 1'b0;
    acc_code = 0;
    exp_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_run = 1'b0;
      d_edge = -1;
      for (int k = 0; k < 6; k++) begin
        h_val[k] = 1'b0;
        h_code[k] = 0;
      end
    end else begin
      if (m_active) begin
        if (m_run) begin
          if (m_ext) begin
            acc = in_valid;
            acc_code = int'(in_code);
          end else begin
            acc = 1'b1;
            acc_code = m_ramp;
          end
          if (acc) begin
            if (m_ext && code_q.size() > 0) void'(code_q.pop_front());
            if (!m_ext) m_ramp = m_up ? (m_ramp + STEP) % 8192 : (m_ramp + 8192 - STEP) % 8192;
            m_left--;
            if (m_left == 0) begin
              m_run = 1'b0;
              d_edge = edge_n + 6;
            end
          end
        end else if (edge_n == d_edge) begin
          exp_done = 1'b1;
          m_active = 1'b0;
        end
      end else if (start) begin
        m_active = 1'b1;
        m_ext = !(mode == 2'b01 || mode == 2'b10);
        m_up = (mode == 2'b01);
        m_left = int'(num_samples);
        m_ramp = int'(ramp_init);
        m_run = (num_samples != 16'd0);
        d_edge = (num_samples == 16'd0) ? edge_n + 5 : -1;
      end
      for (int k = 5; k > 0; k--) begin
        h_val[k] = h_val[k-1];
        h_code[k] = h_code[k-1];
      end
      h_val[0] = acc;
      h_code[0] = acc_code;
    end
    #1;
    for (int k = 1; k <= 5; k++) ev[k] = h_val[k] ? therm(stage_val(h_code[k], k)) : 0;
    exp_sv = {h_val[5], h_val[4], h_val[3], h_val[2], h_val[1]};
    check_val("t1", 32'(t1), ev[1]);
    check_val("t2", 32'(t2), ev[2]);
    check_val("t3", 32'(t3), ev[3]);
    check_val("t4", 32'(t4), ev[4]);
    check_val("t5", 32'(t5), ev[5]);
    check_val("stage_valid", 32'(stage_valid), 32'(exp_sv));
    check_val("busy", 32'(busy), 32'(m_active));
    check_val("done", 32'(done), 32'(exp_done));
    check_val("in_ready", 32'(in_ready), 32'(m_active && m_run && m_ext));
    e = edge_n % 16;
    pc[0][e] = $countones(t1);
    pc[1][e] = $countones(t2);
    pc[2][e] = $countones(t3);
    pc[3][e] = $countones(t4);
    pc[4][e] = $countones(t5);
    if (h_val[5]) begin
      asm_code = pc[0][(edge_n - 4) % 16] * 512 + pc[1][(edge_n - 3) % 16] * 128 +
                 pc[2][(edge_n - 2) % 16] * 32 + pc[3][(edge_n - 1) % 16] * 8 + pc[4][e];
      check_val("assembled", asm_code, h_code[5]);
    end
  endtask

  task automatic drive_data();
    if (valid_q.size() > 0) in_valid = valid_q.pop_front();
    else in_valid = ($urandom_range(0, 9) < 7);
    if (code_q.size() > 0) in_code = code_q[0];
    else in_code = 13'($urandom_range(0, 8191));
  endtask

  task automatic burst(input int md, input int n, input int init, input bit rst_mid, input int rst_at);
    int guard;
    mode = 2'(md);
    num_samples = 16'(n);
    ramp_init = 13'(init);
    start = 1'b1;
    drive_data();
    step();
    start = 1'b0;
    guard = 0;
    while (m_active && guard < 400) begin
      rst = rst_mid && (guard == rst_at);
      drive_data();
      start = ($urandom_range(0, 7) == 0);
      mode = 2'($urandom_range(0, 3));
      num_samples = 16'($urandom_range(0, 20));
      ramp_init = 13'($urandom_range(0, 8191));
      step();
      guard++;
    end
    rst = 1'b0;
    start = 1'b0;
    if (guard >= 400) check_val("burst_bound", 32'(guard), 32'd0);
    code_q.delete();
    valid_q.delete();
    repeat (2) begin
      drive_data();
      step();
    end
  endtask

  initial begin
    int s1, s2, s3, s4, s5;
    rst = 1'b1; start = 1'b0; mode = 2'b00; num_samples = 16'd0;
    ramp_init = 13'd0; in_code = 13'd0; in_valid = 1'b0; x_code = 13'd0;
    for (int k = 0; k < 6; k++) begin
      h_val[k] = 1'b0;
      h_code[k] = 0;
    end
    repeat (3) step();
    rst = 1'b0;
    step();

    code_q = '{13'h1FFF};
    valid_q = '{1'b1};
    burst(0, 1, 0, 1'b0, 0);
    code_q = '{13'h1E00, 13'h0200, 13'h0080};
    valid_q = '{1'b1, 1'b1, 1'b1};
    burst(0, 3, 0, 1'b0, 0);
    burst(1, 3, 8190, 1'b0, 0);
    burst(2, 4, 1, 1'b0, 0);
    code_q = '{13'h0ABC, 13'h1555};
    valid_q = '{1'b1, 1'b0, 1'b1};
    burst(0, 2, 0, 1'b0, 0);
    burst(1, 10, 100, 1'b1, 2);
    burst(1, 3, 5000, 1'b0, 0);
    burst(0, 0, 0, 1'b0, 0);
    burst(2, 0, 7, 1'b0, 0);
    burst(3, 3, 0, 1'b0, 0);
    for (int b = 0; b < 30; b++) begin
      burst($urandom_range(0, 3), $urandom_range(0, 8), $urandom_range(0, 8191),
            ($urandom_range(0, 5) == 0), $urandom_range(0, 6));
    end

    for (int c = 0; c < 8192; c++) begin
      x_code = 13'(c);
      #1;
      s1 = stage_val(c, 1); s2 = stage_val(c, 2); s3 = stage_val(c, 3);
      s4 = stage_val(c, 4); s5 = stage_val(c, 5);
      check_val("split", 32'({x_t1v, x_t2v, x_t3v, x_t4v, x_t5v}),
                (s1 << 13) | (s2 << 10) | (s3 << 7) | (s4 << 4) | s5);
      check_val("recombine", int'(x_t1v) * 512 + int'(x_t2v) * 128 + int'(x_t3v) * 32 +
                int'(x_t4v) * 8 + int'(x_t5v), c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
